sm_regscan_uart_tx: RTL

Board-side register dump transmitter for the schoolMIPS core. It drives the core's debug register read port (`regAddr` out, `regData` in), scans a configured range of the register file, and captures each value once. Each value is sent over an 8N1 UART line as uppercase hex ASCII, one record per register. It sits in the board top next to `sm_top` and replaces the fixed `regAddr` tie-off and LED display with a serial dump that a host can read.

---
 rtl/sm_regscan_uart_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sm_regscan_uart_tx.sv
// rtl/sm_regscan_uart_tx.sv - register-file scan dumped as hex ASCII records over an 8N1 UART
// Define SM_REGSCAN_ADDR_PREFIX_EN to prefix each record with "AA:" (register index in hex).
module sm_regscan_uart_tx #(
    parameter int BAUD_DIV  = 868,
    parameter int REG_FIRST = 0,
    parameter int REG_LAST  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
`ifdef SM_REGSCAN_ADDR_PREFIX_EN
    localparam int NCHAR = 13;
    localparam int DIG0  = 3;
`else
    localparam int NCHAR = 10;
    localparam int DIG0  = 0;
`endif
    localparam logic [3:0] LAST_CHAR = 4'(NCHAR - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_CAPT, S_TX} state_t;

    state_t          state_q, state_d;
    logic [4:0]      addr_q, addr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tx_q, tx_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [3:0]      bit_q, bit_d;
    logic [3:0]      char_q, char_d;
    logic [31:0]     snap_q, snap_d;
    logic [7:0]      cur_char;
    logic [2:0]      dig_idx;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character currently being shifted out, selected by position in the record.
    always_comb begin
        dig_idx = 3'(char_q - 4'(DIG0));
        if (char_q == LAST_CHAR) begin
            cur_char = 8'h0A;
        end else if (char_q == LAST_CHAR - 4'd1) begin
            cur_char = 8'h0D;
`ifdef SM_REGSCAN_ADDR_PREFIX_EN
        end else if (char_q == 4'd0) begin
            cur_char = hex_ascii({3'b000, addr_q[4]});
        end else if (char_q == 4'd1) begin
            cur_char = hex_ascii(addr_q[3:0]);
        end else if (char_q == 4'd2) begin
            cur_char = 8'h3A;
`endif
        end else begin
            cur_char = hex_ascii(snap_q[{~dig_idx, 2'b00} +: 4]);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tx_d    = tx_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        char_d  = char_q;
        snap_d  = snap_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADDR;
                    addr_d  = 5'(REG_FIRST);
                    busy_d  = 1'b1;
                end
            end
            S_ADDR: state_d = S_CAPT;
            S_CAPT: begin
                state_d = S_TX;
                snap_d  = regData;
                tx_d    = 1'b0;
                baud_d  = '0;
                bit_d   = 4'd0;
                char_d  = 4'd0;
            end
            S_TX: begin
                if (baud_q == BW'(BAUD_DIV - 1)) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d = 4'd0;
                        if (char_q == LAST_CHAR) begin
                            char_d = 4'd0;
                            tx_d   = 1'b1;
                            if (addr_q == 5'(REG_LAST)) begin
                                state_d = S_IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_ADDR;
                                addr_d  = addr_q + 5'd1;
                            end
                        end else begin
                            char_d = char_q + 4'd1;
                            tx_d   = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_char[bit_q[2:0]];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            char_q  <= 4'd0;
            snap_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            snap_q  <= snap_d;
        end
    end

    assign regAddr = addr_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule
